// File: rtl/fetch_sequencer.sv
// Instruction-ROM program sequencer: PC, call/return stack, fetch/issue handshake.
// Define FETCH_STACK_CHECK_EN for stack overflow/underflow detection with a sticky stk_err.
module fetch_sequencer #(
    parameter int WORD_WIDTH  = 24,
    parameter int ADDR_BITS   = 8,
    parameter int STACK_DEPTH = 8,
    localparam int SP_BITS    = $clog2(STACK_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [WORD_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    output logic [WORD_WIDTH-17:0] opcode,
    output logic [15:0]           operand,
    output logic [ADDR_BITS-1:0]  pc,
    input  logic                  done,
    input  logic [2:0]            flow_op,
    input  logic                  acu_nz,
    output logic [SP_BITS-1:0]    sp,
    output logic                  stk_err
);
    localparam int PTR_BITS = SP_BITS - 1;

    localparam logic [2:0] OP_JMP = 3'd1;
    localparam logic [2:0] OP_JMA = 3'd2;
    localparam logic [2:0] OP_CLL = 3'd3;
    localparam logic [2:0] OP_RET = 3'd4;
    localparam logic [2:0] OP_RST = 3'd5;

    typedef enum logic {S_FETCH, S_ISSUE} state_t;

    state_t                 state, state_nx;
    logic [ADDR_BITS-1:0]   pc_q, pc_nx, pc_inc, target;
    logic [WORD_WIDTH-1:0]  ir_q;
    logic [SP_BITS-1:0]     sp_q, sp_nx;
    logic [PTR_BITS-1:0]    ptr, ptr_inc, ptr_dec;
    logic                   push, load_ir;
    logic [ADDR_BITS-1:0]   stack [STACK_DEPTH];
`ifdef FETCH_STACK_CHECK_EN
    logic                   err_q, err_nx;
`endif

    assign pc_inc  = pc_q + ADDR_BITS'(1);
    assign target  = ir_q[ADDR_BITS-1:0];
    assign ptr     = sp_q[PTR_BITS-1:0];
    assign ptr_inc = ptr + PTR_BITS'(1);
    assign ptr_dec = ptr - PTR_BITS'(1);

    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        sp_nx    = sp_q;
        push     = 1'b0;
        load_ir  = 1'b0;
`ifdef FETCH_STACK_CHECK_EN
        err_nx   = err_q;
`endif
        if (en) begin
            case (state)
                S_FETCH: begin
                    load_ir  = 1'b1;
                    state_nx = S_ISSUE;
                end
                S_ISSUE: begin
                    if (done) begin
                        state_nx = S_FETCH;
                        case (flow_op)
                            OP_JMP: pc_nx = target;
                            OP_JMA: pc_nx = acu_nz ? target : pc_inc;
                            OP_CLL: begin
`ifdef FETCH_STACK_CHECK_EN
                                if (sp_q == SP_BITS'(STACK_DEPTH)) begin
                                    pc_nx  = pc_inc;
                                    err_nx = 1'b1;
                                end else begin
                                    push  = 1'b1;
                                    sp_nx = sp_q + SP_BITS'(1);
                                    pc_nx = target;
                                end
`else
                                push  = 1'b1;
                                sp_nx = {1'b0, ptr_inc};
                                pc_nx = target;
`endif
                            end
                            OP_RET: begin
`ifdef FETCH_STACK_CHECK_EN
                                if (sp_q == '0) begin
                                    pc_nx  = pc_inc;
                                    err_nx = 1'b1;
                                end else begin
                                    sp_nx = sp_q - SP_BITS'(1);
                                    pc_nx = stack[ptr_dec];
                                end
`else
                                sp_nx = {1'b0, ptr_dec};
                                pc_nx = stack[ptr_dec];
`endif
                            end
                            OP_RST: begin
                                pc_nx = '0;
                                sp_nx = '0;
                            end
                            default: pc_nx = pc_inc;
                        endcase
                    end
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            ir_q <= '0;
            sp_q <= '0;
        end else begin
            if (load_ir) ir_q <= rom_data;
            pc_q <= pc_nx;
            sp_q <= sp_nx;
        end
    end

    // Stack RAM carries no reset; entries are only meaningful once pushed.
    always_ff @(posedge clk) begin
        if (push) stack[ptr] <= pc_inc;
    end

`ifdef FETCH_STACK_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_nx;
    end
    assign stk_err = err_q;
`else
    assign stk_err = 1'b0;
`endif

    assign rom_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_valid = (state == S_ISSUE);
    assign opcode      = ir_q[WORD_WIDTH-1:16];
    assign operand     = ir_q[15:0];
    assign sp          = sp_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: flow ops, stack limits, enable hold, async reset.
module tb_fetch_sequencer;
    localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, JMA = 3'd2, CLL = 3'd3, RET = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        instr_valid;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [7:0]  pc;
    logic        done = 1'b0;
    logic [2:0]  flow_op = 3'd0;
    logic        acu_nz = 1'b0;
    logic [3:0]  sp;
    logic        stk_err;

    logic [23:0] rom [256];
    int n_chk = 0;
    int n_pass = 0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_valid(instr_valid), .opcode(opcode), .operand(operand), .pc(pc),
        .done(done), .flow_op(flow_op), .acu_nz(acu_nz), .sp(sp), .stk_err(stk_err)
    );

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_ir(input logic [7:0] a);
        logic [23:0] w;
        w = rom[a];
        chk("ir_valid", 32'(instr_valid), 32'd1);
        chk("opcode", 32'(opcode), 32'(w[23:16]));
        chk("operand", 32'(operand), 32'(w[15:0]));
    endtask

    // Called at a negedge while in ISSUE; retires and checks the refetch.
    task automatic exec(input logic [2:0] f, input logic acu, input logic [7:0] exp_pc);
        done = 1'b1; flow_op = f; acu_nz = acu;
        @(negedge clk);
        done = 1'b0;
        chk("valid_drop", 32'(instr_valid), 32'd0);
        chk("pc", 32'(pc), 32'(exp_pc));
        chk("rom_addr", 32'(rom_addr), 32'(exp_pc));
        @(negedge clk);
        chk_ir(exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'(i * 3 + 1), 8'hC3, 8'(i + 8'h80)};
        rom[0][7:0] = 8'd40;  rom[1][7:0] = 8'd20;  rom[2][7:0] = 8'd255;
        rom[3][7:0] = 8'd8;   rom[6][7:0] = 8'd8;   rom[8][7:0] = 8'd6;
        rom[10][7:0] = 8'd9;  rom[20][7:0] = 8'd25;
        for (int k = 0; k < 9; k++) rom[40 + 2 * k][7:0] = 8'(42 + 2 * k);

        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_sp", 32'(sp), 32'd0);
        chk("rst_err", 32'(stk_err), 32'd0);
        rst = 1'b0;
        chk("fetch_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("pc0", 32'(pc), 32'd0);
        chk_ir(8'd0);

        exec(NXT, 1'b0, 8'd1);
        exec(NXT, 1'b0, 8'd2);
        exec(3'd7, 1'b0, 8'd3);
        exec(JMP, 1'b0, 8'd8);
        exec(JMA, 1'b1, 8'd6);
        exec(JMP, 1'b0, 8'd8);
        exec(JMA, 1'b0, 8'd9);

        en = 1'b0; done = 1'b1; flow_op = NXT;
        repeat (5) @(negedge clk);
        chk("hold_pc", 32'(pc), 32'd9);
        chk_ir(8'd9);
        en = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("resume_valid", 32'(instr_valid), 32'd0);
        chk("resume_pc", 32'(pc), 32'd10);
        @(negedge clk);
        chk_ir(8'd10);
        exec(JMP, 1'b0, 8'd9);

        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_pc", 32'(pc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_ir(8'd0);

        exec(NXT, 1'b0, 8'd1);
        exec(CLL, 1'b0, 8'd20);
        chk("call_sp", 32'(sp), 32'd1);
        exec(JMP, 1'b0, 8'd25);
        exec(RET, 1'b0, 8'd2);
        chk("ret_sp", 32'(sp), 32'd0);
        exec(JMP, 1'b0, 8'd255);
        exec(NXT, 1'b0, 8'd0);

        exec(JMP, 1'b0, 8'd40);
        for (int k = 0; k < 8; k++) exec(CLL, 1'b0, 8'(42 + 2 * k));
`ifdef FETCH_STACK_CHECK_EN
        chk("full_sp", 32'(sp), 32'd8);
        exec(CLL, 1'b0, 8'd57);
        chk("ovf_sp", 32'(sp), 32'd8);
        chk("ovf_err", 32'(stk_err), 32'd1);
        for (int k = 0; k < 8; k++) exec(RET, 1'b0, 8'(55 - 2 * k));
        chk("empty_sp", 32'(sp), 32'd0);
        exec(RET, 1'b0, 8'd42);
        chk("unf_sp", 32'(sp), 32'd0);
        chk("unf_err", 32'(stk_err), 32'd1);
`else
        chk("wrap_sp", 32'(sp), 32'd0);
        exec(CLL, 1'b0, 8'd58);
        chk("wrap9_sp", 32'(sp), 32'd1);
        exec(RET, 1'b0, 8'd57);
        chk("pop_sp", 32'(sp), 32'd0);
        exec(RET, 1'b0, 8'd55);
        chk("unf_sp", 32'(sp), 32'd7);
        chk("no_err", 32'(stk_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program sequencer for the instruction ROM (24-bit words, 8-bit address, combinational read). Owns the program counter and a hardware call/return stack, drives the ROM address, and latches each fetched word into an instruction register for the control unit. The control unit reports each instruction's flow outcome (next, jump, conditional jump, call, return, reset) via a done handshake; the sequencer then computes the next PC and fetches again.

Parameters:
WORD_WIDTH, 24, ROM word width; opcode = [WORD_WIDTH-1:16], operand = [15:0]
ADDR_BITS, 8, ROM address / PC width
STACK_DEPTH, 8, call-stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  0 freezes FSM, PC, IR and stack
rom_addr  out  ADDR_BITS  address to ROM
rom_data  in  WORD_WIDTH  ROM read data, valid same cycle as rom_addr
instr_valid  out  1  IR holds an instruction awaiting done
opcode  out  WORD_WIDTH-16  IR opcode field
operand  out  16  IR operand field
pc  out  ADDR_BITS  address of instruction currently in IR
done  in  1  control unit finished current instruction; sampled only when instr_valid=1
flow_op  in  3  0 NEXT, 1 JMP, 2 JMA, 3 CLL, 4 RET, 5 RST, 6-7 treated as NEXT
acu_nz  in  1  accumulator non-zero; qualifies JMA
sp  out  log2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH
stk_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset (async, rst=1): state=FETCH, pc=0, rom_addr=0, IR=0, instr_valid=0, sp=0, stk_err=0. Stack contents undefined, not cleared.
- FSM, two states; all transitions gated by en=1.
- FETCH: rom_addr=pc; next edge latches rom_data into IR, instr_valid<=1, -> ISSUE. Fetch latency 1 cycle.
- ISSUE: instr_valid=1, rom_addr holds pc. done=0: stay. done=1: instr_valid<=0, pc<=next_pc, -> FETCH.
- Throughput: 2 cycles per instruction minimum; done in the first ISSUE cycle is legal.
- next_pc, target = operand[ADDR_BITS-1:0] (upper operand bits ignored):
  NEXT: pc+1, modulo 2^ADDR_BITS (255 -> 0).
  JMP: target.
  JMA: target if acu_nz=1, else pc+1.
  CLL: push pc+1 (mod 2^ADDR_BITS), sp+1, pc<=target.
  RET: pop, sp-1, pc<=popped value.
  RST: pc<=0, sp<=0; stk_err unchanged.
- Overflow (CLL with sp=STACK_DEPTH): no push, pc<=pc+1, stk_err<=1.
- Underflow (RET with sp=0): no pop, pc<=pc+1, stk_err<=1.
- stk_err clears only on rst.
- done while instr_valid=0 is ignored.
- en=0: everything holds. A done pulse during en=0 is lost; the control unit holds done until en=1.
- rst mid-ISSUE: IR invalidated at once, restart at address 0 on next edge after release.
- Outputs registered except rom_addr, which is a direct copy of the pc register.

Optional Feature:
FETCH_STACK_CHECK_EN
- Defined: overflow/underflow detection as above; stk_err is live.
- Undefined: no checking. stk_err tied to 0. Stack pointer wraps modulo STACK_DEPTH; overflow overwrites the oldest entry; underflow returns whatever the wrapped slot holds. sp reports the wrapped pointer with MSB 0.

Test Plan:
- Reset then NEXT x3: ROM[0..2] presented; pc 0,1,2; instr_valid rises 1 cycle after each FETCH; opcode/operand match ROM words.
- JMA target 6 with acu_nz=1 then acu_nz=0, at pc=8: first pc->6; second pc->9.
- CLL 20 at pc=1, then RET at pc=25: sp 0->1->0; pc 20, then 2.
- Nine nested CLLs (STACK_DEPTH=8) with macro defined: 9th leaves sp=8, pc=caller+1, stk_err=1. Then RET at sp=0: stk_err remains 1.
- Macro undefined, RET at sp=0: stk_err=0, no X on pc.
- en=0 for 5 cycles in ISSUE with done=1: pc, IR and state unchanged; after en=1, advance on first cycle.
- Assert rst in ISSUE at pc=9: instr_valid=0 and pc=0 immediately (async); after release ROM[0] is fetched.
- NEXT at pc=255: pc wraps to 0.
